// File: rtl/filter_test_sequencer.sv
// filter_test_sequencer: drives a filter test run from stimulus ROM to result RAM
// Ports:
//   clk      - single clock, rising-edge
//   rst      - asynchronous active-low reset
//   start    - request one run (accepted only in IDLE)
//   abort    - cancel a run in progress
//   len      - run length latched with start, 0 means 2^ADDR_W
//   filt_clr - one-cycle filter clear pulse
//   rd_en    - ROM read strobe / filter input valid
//   rom_addr - ROM address
//   ram_wren - result RAM write enable (rd_en delayed by MEM_LAT+FILT_LAT)
//   ram_addr - result RAM address (rom_addr delayed by MEM_LAT+FILT_LAT)
//   busy     - high whenever not IDLE
//   done     - one-cycle completion pulse
module filter_test_sequencer #(
    parameter int ADDR_W   = 8,
    parameter int MEM_LAT  = 1,
    parameter int FILT_LAT = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    input  logic [ADDR_W-1:0] len,
    output logic              filt_clr,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rom_addr,
    output logic              ram_wren,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              busy,
    output logic              done
);
    localparam int D = MEM_LAT + FILT_LAT;

    typedef enum logic [2:0] {IDLE, CLEAR, RUN, DRAIN, DONE} stateT;

    stateT             state, nxt;
    logic [ADDR_W:0]   runLen, issued;
    logic [D-1:0]      wrPipe, lowPipe;
    logic [ADDR_W-1:0] addrPipe [D];
    logic              active;

    assign active   = (state == CLEAR) || (state == RUN) || (state == DRAIN);
    // Pipe without its output stage: nonzero means writes are still pending.
    assign lowPipe  = wrPipe << 1;
    assign ram_wren = wrPipe[D-1];
    assign ram_addr = addrPipe[D-1];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= nxt;
    end

    always_comb begin
        nxt = state;
        if (active && abort) nxt = IDLE;
        else begin
            case (state)
                IDLE:    nxt = start ? CLEAR : IDLE;
                CLEAR:   nxt = RUN;
                RUN:     nxt = (issued == runLen) ? DRAIN : RUN;
                DRAIN:   nxt = (lowPipe == '0) ? DONE : DRAIN;
                DONE:    nxt = IDLE;
                default: nxt = IDLE;
            endcase
        end
    end

    // Outputs are registered from the next state so they line up with the state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            filt_clr <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            rd_en    <= 1'b0;
            rom_addr <= '0;
            runLen   <= '0;
            issued   <= '0;
            wrPipe   <= '0;
            for (int i = 0; i < D; i++) addrPipe[i] <= '0;
        end else begin
            filt_clr <= nxt == CLEAR;
            busy     <= nxt != IDLE;
            done     <= nxt == DONE;
            rd_en    <= nxt == RUN;
            // len of 0 becomes 2^ADDR_W via the extra top bit.
            if (state == IDLE && start) runLen <= {len == '0, len};
            if (nxt == RUN) begin
                rom_addr <= (state == CLEAR) ? '0 : issued[ADDR_W-1:0];
                issued   <= (state == CLEAR) ? (ADDR_W+1)'(1) : issued + 1'b1;
            end
            if (active && abort) begin
                wrPipe <= '0;
                for (int i = 0; i < D; i++) addrPipe[i] <= '0;
            end else begin
                wrPipe      <= (wrPipe << 1) | D'(rd_en);
                addrPipe[0] <= rom_addr;
                for (int i = 1; i < D; i++) addrPipe[i] <= addrPipe[i-1];
            end
        end
    end
endmodule

// File: tb/tb_filter_test_sequencer.sv
// tb_filter_test_sequencer: directed self-checking bench for filter_test_sequencer
// Cycle k is the interval ending at the k-th rising edge after the start edge (cycle 0).
// Outputs are sampled and inputs driven on falling edges.
module tb_filter_test_sequencer;
    localparam int AW = 8;

    logic          clk    = 1'b0;
    logic          rst    = 1'b1;
    logic          start  = 1'b0;
    logic          abort  = 1'b0;
    logic [AW-1:0] len    = '0;
    logic          start1 = 1'b0;
    logic [AW-1:0] len1   = '0;
    logic          filt_clr, rd_en, ram_wren, busy, done;
    logic [AW-1:0] rom_addr, ram_addr;
    logic          filt_clr1, rd_en1, ram_wren1, busy1, done1;
    logic [AW-1:0] rom_addr1, ram_addr1;
    int            checks = 0;
    int            errors = 0;

    always #5 clk = ~clk;

    filter_test_sequencer #(.ADDR_W(AW), .MEM_LAT(1), .FILT_LAT(4)) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort), .len(len),
        .filt_clr(filt_clr), .rd_en(rd_en), .rom_addr(rom_addr),
        .ram_wren(ram_wren), .ram_addr(ram_addr), .busy(busy), .done(done)
    );

    filter_test_sequencer #(.ADDR_W(AW), .MEM_LAT(1), .FILT_LAT(0)) dut1 (
        .clk(clk), .rst(rst), .start(start1), .abort(1'b0), .len(len1),
        .filt_clr(filt_clr1), .rd_en(rd_en1), .rom_addr(rom_addr1),
        .ram_wren(ram_wren1), .ram_addr(ram_addr1), .busy(busy1), .done(done1)
    );

    task automatic test_reset();
        #3 rst = 1'b0;
        #1;
        checks++;
        if ({filt_clr, rd_en, rom_addr, ram_wren, ram_addr, busy, done} !== '0) begin
            errors++;
            $display("FAIL reset outputs got %b exp all zero",
                     {filt_clr, rd_en, rom_addr, ram_wren, ram_addr, busy, done});
        end
        checks++;
        if ({filt_clr1, rd_en1, rom_addr1, ram_wren1, ram_addr1, busy1, done1} !== '0) begin
            errors++;
            $display("FAIL reset outputs dut1 got %b exp all zero",
                     {filt_clr1, rd_en1, rom_addr1, ram_wren1, ram_addr1, busy1, done1});
        end
        @(negedge clk);
        rst = 1'b1;
    endtask

    // One len=4 run from a falling edge; startMask[k]/abortCyc give inputs driven in cycle k.
    task automatic run4(input int abortCyc, input logic [15:0] startMask, input int lastK,
                        input logic [AW-1:0] prevAddr, input string tag);
        bit ab, eFilt, eBusy, eRd, eWr, eDone;
        int effK;
        logic [AW-1:0] eRom;
        len   = AW'(4);
        start = 1'b1;
        abort = 1'b0;
        for (int k = 1; k <= lastK; k++) begin
            @(negedge clk);
            ab    = abortCyc >= 0 && k > abortCyc;
            effK  = ab ? abortCyc : k;
            eFilt = k == 1 || (k == 13 && startMask[12]);
            eBusy = (k <= 11 && !ab) || (k >= 13 && startMask[12]);
            eRd   = k >= 2 && k <= 5 && !ab;
            eWr   = k >= 7 && k <= 10 && !ab;
            eDone = k == 11 && !ab;
            eRom  = effK < 2 ? prevAddr : effK > 5 ? AW'(3) : AW'(effK - 2);
            checks++;
            if (filt_clr !== eFilt) begin
                errors++;
                $display("FAIL %s filt_clr cycle %0d got %b exp %b", tag, k, filt_clr, eFilt);
            end
            checks++;
            if (busy !== eBusy) begin
                errors++;
                $display("FAIL %s busy cycle %0d got %b exp %b", tag, k, busy, eBusy);
            end
            checks++;
            if (rd_en !== eRd) begin
                errors++;
                $display("FAIL %s rd_en cycle %0d got %b exp %b", tag, k, rd_en, eRd);
            end
            checks++;
            if (rom_addr !== eRom) begin
                errors++;
                $display("FAIL %s rom_addr cycle %0d got %0d exp %0d", tag, k, rom_addr, eRom);
            end
            checks++;
            if (ram_wren !== eWr) begin
                errors++;
                $display("FAIL %s ram_wren cycle %0d got %b exp %b", tag, k, ram_wren, eWr);
            end
            if (eWr) begin
                checks++;
                if (ram_addr !== AW'(k - 7)) begin
                    errors++;
                    $display("FAIL %s ram_addr cycle %0d got %0d exp %0d", tag, k, ram_addr, k - 7);
                end
            end
            checks++;
            if (done !== eDone) begin
                errors++;
                $display("FAIL %s done cycle %0d got %b exp %b", tag, k, done, eDone);
            end
            start = startMask[k];
            abort = k == abortCyc;
        end
        start = 1'b0;
        abort = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        bit seen = 0;
        for (int i = 0; i < 30 && !seen; i++) begin
            @(negedge clk);
            start = 1'b0;
            seen  = done;
        end
        @(negedge clk);
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL %s drain_done got 0 exp 1 within 30 cycles", tag);
        end
    endtask

    task automatic test_basic();
        run4(-1, 16'h0000, 14, AW'(0), "basic");
    endtask

    task automatic test_len0();
        int rdCnt = 0, wrCnt = 0, doneCnt = 0;
        len   = '0;
        start = 1'b1;
        for (int k = 1; k <= 300; k++) begin
            @(negedge clk);
            start = 1'b0;
            if (rd_en) begin
                checks++;
                if (rom_addr !== AW'(rdCnt)) begin
                    errors++;
                    $display("FAIL len0 rom_addr cycle %0d got %0d exp %0d", k, rom_addr, rdCnt);
                end
                rdCnt++;
            end
            if (ram_wren) begin
                checks++;
                if (ram_addr !== AW'(wrCnt)) begin
                    errors++;
                    $display("FAIL len0 ram_addr cycle %0d got %0d exp %0d", k, ram_addr, wrCnt);
                end
                wrCnt++;
            end
            if (done) doneCnt++;
        end
        checks++;
        if (rdCnt != 256) begin
            errors++;
            $display("FAIL len0 rd_count got %0d exp 256", rdCnt);
        end
        checks++;
        if (wrCnt != 256) begin
            errors++;
            $display("FAIL len0 wr_count got %0d exp 256", wrCnt);
        end
        checks++;
        if (doneCnt != 1) begin
            errors++;
            $display("FAIL len0 done_count got %0d exp 1", doneCnt);
        end
    endtask

    task automatic test_abort();
        run4(4, 16'h0000, 12, AW'(255), "abort");
        run4(-1, 16'h0000, 14, AW'(2), "after_abort");
    endtask

    task automatic test_start_ignore();
        run4(-1, 16'h1808, 13, AW'(3), "start_ignore");
        wait_done("start_ignore");
    endtask

    task automatic test_reset_mid();
        len   = AW'(4);
        start = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            start = 1'b0;
        end
        checks++;
        if (ram_wren !== 1'b1 || ram_addr !== AW'(1)) begin
            errors++;
            $display("FAIL reset_mid pre_write got wren=%b addr=%0d exp wren=1 addr=1", ram_wren, ram_addr);
        end
        #2 rst = 1'b0;
        #1;
        checks++;
        if ({filt_clr, rd_en, rom_addr, ram_wren, ram_addr, busy, done} !== '0) begin
            errors++;
            $display("FAIL reset_mid outputs got %b exp all zero",
                     {filt_clr, rd_en, rom_addr, ram_wren, ram_addr, busy, done});
        end
        @(negedge clk);
        rst = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            checks++;
            if ({ram_wren, done, busy} !== 3'b000) begin
                errors++;
                $display("FAIL reset_mid quiet cycle %0d got wren/done/busy=%b exp 000", k, {ram_wren, done, busy});
            end
        end
        rst = 1'b0;
        @(negedge clk);
        rst   = 1'b1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        checks++;
        if (filt_clr !== 1'b1 || busy !== 1'b1) begin
            errors++;
            $display("FAIL first_start got filt_clr=%b busy=%b exp 1 1", filt_clr, busy);
        end
        wait_done("reset_mid");
    endtask

    task automatic test_short_d1();
        len1   = AW'(1);
        start1 = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            start1 = 1'b0;
            checks++;
            if ({filt_clr1, rd_en1, ram_wren1, done1, busy1} !==
                {k == 1, k == 2, k == 3, k == 4, k >= 1 && k <= 4}) begin
                errors++;
                $display("FAIL short_d1 cycle %0d clr/rd/wr/done/busy got %b exp %b", k,
                         {filt_clr1, rd_en1, ram_wren1, done1, busy1},
                         {k == 1, k == 2, k == 3, k == 4, k >= 1 && k <= 4});
            end
            if (k == 3) begin
                checks++;
                if (ram_addr1 !== '0) begin
                    errors++;
                    $display("FAIL short_d1 ram_addr got %0d exp 0", ram_addr1);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_len0();
        test_abort();
        test_start_ignore();
        test_reset_mid();
        test_short_d1();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
